ad9363_port_emu: RTL

- Cycle-level digital model of the AD9363 side of the 1R1T dual-port FDD single-data-rate interface. It is synthesizable and also used in simulation.
- Drives the RX port (rx_frame, p0_d) toward the baseband streamer from an internal sample source.
- Captures the TX port (tx_frame, p1_d) from the baseband streamer into a sample sink.
- Used for on-board loopback and for closed-loop benches of the FPGA streaming path, with no RF chip attached.

---
 rtl/ad9363_port_emu_if.sv | 29 ++
 rtl/ad9363_port_emu.sv | 100 ++++++++++
 2 files changed

// File: rtl/ad9363_port_emu_if.sv
// Port bundle between the AD9363 emulator and the baseband streamer: sample
// source, RX port, TX port and sample sink.
interface ad9363_port_emu_if #(
    parameter int unsigned DATA_W = 12
);
    logic              src_valid;
    logic [DATA_W-1:0] src_i;
    logic [DATA_W-1:0] src_q;
    logic              src_ready;
    logic              rx_frame;
    logic [DATA_W-1:0] p0_d;
    logic              tx_frame;
    logic [DATA_W-1:0] p1_d;
    logic              snk_valid;
    logic [DATA_W-1:0] snk_i;
    logic [DATA_W-1:0] snk_q;

    // Emulator side.
    modport slave (
        input  src_valid, src_i, src_q, tx_frame, p1_d,
        output src_ready, rx_frame, p0_d, snk_valid, snk_i, snk_q
    );

    // Baseband streamer / bench side.
    modport master (
        output src_valid, src_i, src_q, tx_frame, p1_d,
        input  src_ready, rx_frame, p0_d, snk_valid, snk_i, snk_q
    );
endinterface

// File: rtl/ad9363_port_emu.sv
// AD9363 side of the 1R1T dual-port FDD SDR interface: free-running RX driver
// fed from a sample source, two-stage TX capture into a sample sink.
module ad9363_port_emu #(
    parameter int unsigned       DATA_W    = 12,
    parameter logic [DATA_W-1:0] IDLE_WORD = '0,
    parameter int unsigned       CNT_W     = 16
) (
    input  logic                 data_clk,
    input  logic                 arst,
    ad9363_port_emu_if.slave     bus,
    output logic [CNT_W-1:0]     underrun_cnt,
    output logic [CNT_W-1:0]     frame_err_cnt
);
    localparam logic PH_I = 1'b0;
    localparam logic PH_Q = 1'b1;

    logic              ph;
    logic              src_ready_c;
    logic              take;
    logic              rx_frame_r;
    logic [DATA_W-1:0] p0_r;
    logic [DATA_W-1:0] q_hold;

    logic              f_r;
    logic [DATA_W-1:0] d_r;
    logic              have_i;
    logic [DATA_W-1:0] cap_i;
    logic              snk_valid_r;
    logic [DATA_W-1:0] snk_i_r;
    logic [DATA_W-1:0] snk_q_r;

    always_comb begin
        src_ready_c = ~arst & (ph == PH_I);
        take        = bus.src_valid & src_ready_c;
    end

    assign bus.src_ready = src_ready_c;
    assign bus.rx_frame  = rx_frame_r;
    assign bus.p0_d      = p0_r;
    assign bus.snk_valid = snk_valid_r;
    assign bus.snk_i     = snk_i_r;
    assign bus.snk_q     = snk_q_r;

    // RX driver: the phase never stalls, missing source samples become idle words.
    always_ff @(posedge data_clk) begin
        if (arst) begin
            ph           <= PH_I;
            rx_frame_r   <= 1'b0;
            p0_r         <= '0;
            q_hold       <= '0;
            underrun_cnt <= '0;
        end else begin
            ph <= ~ph;
            if (ph == PH_I) begin
                rx_frame_r <= 1'b1;
                if (take) begin
                    p0_r   <= bus.src_i;
                    q_hold <= bus.src_q;
                end else begin
                    p0_r   <= IDLE_WORD;
                    q_hold <= IDLE_WORD;
                    if (underrun_cnt != '1)
                        underrun_cnt <= underrun_cnt + 1'b1;
                end
            end else begin
                rx_frame_r <= 1'b0;
                p0_r       <= q_hold;
            end
        end
    end

    // TX capture: pins are registered first, framing is decoded one cycle later.
    always_ff @(posedge data_clk) begin
        if (arst) begin
            f_r           <= 1'b0;
            d_r           <= '0;
            have_i        <= 1'b0;
            cap_i         <= '0;
            snk_valid_r   <= 1'b0;
            snk_i_r       <= '0;
            snk_q_r       <= '0;
            frame_err_cnt <= '0;
        end else begin
            f_r         <= bus.tx_frame;
            d_r         <= bus.p1_d;
            snk_valid_r <= 1'b0;
            if (f_r) begin
                cap_i  <= d_r;
                have_i <= 1'b1;
                if (have_i && frame_err_cnt != '1)
                    frame_err_cnt <= frame_err_cnt + 1'b1;
            end else if (have_i) begin
                snk_i_r     <= cap_i;
                snk_q_r     <= d_r;
                snk_valid_r <= 1'b1;
                have_i      <= 1'b0;
            end
        end
    end
endmodule
